// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//
// Sequences a single-port 64x32 register file that does either one
// two-operand read or one write per clock edge. Write-back traffic is queued
// in a small FIFO write buffer. Decode reads are served whenever the buffer
// allows it. A write is forced when any of these holds:
//   - the buffer is full
//   - a pending entry targets one of the read operands
//   - the buffer has waited MAX_WAIT cycles without draining
//
// Ports
//   clock, reset                 system clock, synchronous active-high reset
//   rd_req / rd_rs_addr / rd_rt_addr   decode read request and operand addresses
//   rd_ack                       read issued to the register file this cycle
//   rd_valid, rd_rs_data, rd_rt_data   operand data, one cycle after rd_ack
//   wb_req / wb_addr / wb_data   write-back offer
//   wb_ready                     buffer can accept a write this cycle
//   wb_count                     number of buffered writes
//   rf_rs_addr, rf_rt_addr, rf_rd_addr, rf_write, rf_data_in   register file controls
//   rf_rs, rf_rt                 register file read data
module regfile_access_ctrl #(
   parameter int WB_DEPTH = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       rd_req,
   input  logic [5:0]                 rd_rs_addr,
   input  logic [5:0]                 rd_rt_addr,
   output logic                       rd_ack,
   output logic                       rd_valid,
   output logic [31:0]                rd_rs_data,
   output logic [31:0]                rd_rt_data,
   input  logic                       wb_req,
   input  logic [5:0]                 wb_addr,
   input  logic [31:0]                wb_data,
   output logic                       wb_ready,
   output logic [$clog2(WB_DEPTH):0]  wb_count,
   output logic [5:0]                 rf_rs_addr,
   output logic [5:0]                 rf_rt_addr,
   output logic [5:0]                 rf_rd_addr,
   output logic                       rf_write,
   output logic [31:0]                rf_data_in,
   input  logic [31:0]                rf_rs,
   input  logic [31:0]                rf_rt
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int AGE_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10
   } op_e;

   logic [5:0]          buf_addr_q [WB_DEPTH];
   logic [5:0]          buf_addr_d [WB_DEPTH];
   logic [31:0]         buf_data_q [WB_DEPTH];
   logic [31:0]         buf_data_d [WB_DEPTH];
   logic [WB_DEPTH-1:0] buf_vld_q, buf_vld_d;
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [AGE_W-1:0]    age_q, age_d;
   logic                rd_valid_q, rd_valid_d;

   logic empty_s, full_s, hazard_s, age_max_s, enq_s, deq_s;
   op_e  op_s;

   assign empty_s   = (count_q == {CNT_W{1'b0}});
   assign full_s    = (count_q == CNT_W'(WB_DEPTH));
   assign age_max_s = (age_q == AGE_W'(MAX_WAIT));

   // A read hazards when either operand matches any still-buffered write.
   always_comb begin
      hazard_s = 1'b0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         hazard_s = hazard_s | (buf_vld_q[i] &
                    ((buf_addr_q[i] == rd_rs_addr) | (buf_addr_q[i] == rd_rt_addr)));
      end
      hazard_s = hazard_s & rd_req;
   end

   // Pick this cycle's register-file operation.
   // An empty buffer never writes, so a write offered alongside a read is
   // ordered after it and the read sees the old value.
   always_comb begin
      op_s = OP_IDLE;
      if (reset) begin
         op_s = OP_IDLE;
      end else if (empty_s) begin
         if (rd_req) begin
            op_s = OP_READ;
         end else begin
            op_s = OP_IDLE;
         end
      end else if (full_s || hazard_s || age_max_s || !rd_req) begin
         op_s = OP_WRITE;
      end else begin
         op_s = OP_READ;
      end
   end

   assign rd_ack     = (op_s == OP_READ);
   assign rf_write   = (op_s == OP_WRITE);
   assign wb_ready   = !reset && !full_s;
   assign enq_s      = wb_req && wb_ready;
   assign deq_s      = rf_write;

   assign rf_rs_addr = rd_rs_addr;
   assign rf_rt_addr = rd_rt_addr;
   assign rf_rd_addr = buf_addr_q[head_q];
   assign rf_data_in = buf_data_q[head_q];
   assign rd_rs_data = rf_rs;
   assign rd_rt_data = rf_rt;
   assign rd_valid   = rd_valid_q;
   assign wb_count   = count_q;

   // Next state of the write buffer, its age counter and the read-valid flag.
   // Enqueue and dequeue never touch the same slot: dequeue needs a non-empty
   // buffer and enqueue needs a non-full one.
   always_comb begin
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      buf_vld_d  = buf_vld_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      age_d      = age_q;
      rd_valid_d = rd_ack;

      if (deq_s) begin
         buf_vld_d[head_q] = 1'b0;
         head_d            = head_q + PTR_W'(1);
      end else begin
         head_d = head_q;
      end

      if (enq_s) begin
         buf_addr_d[tail_q] = wb_addr;
         buf_data_d[tail_q] = wb_data;
         buf_vld_d[tail_q]  = 1'b1;
         tail_d             = tail_q + PTR_W'(1);
      end else begin
         tail_d = tail_q;
      end

      case ({enq_s, deq_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (empty_s || deq_s) begin
         age_d = {AGE_W{1'b0}};
      end else if (age_max_s) begin
         age_d = age_q;
      end else begin
         age_d = age_q + AGE_W'(1);
      end
   end

   // State registers; reset discards buffered writes and any pending read.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < WB_DEPTH; i++) begin
            buf_addr_q[i] <= 6'd0;
            buf_data_q[i] <= 32'd0;
         end
         buf_vld_q  <= {WB_DEPTH{1'b0}};
         head_q     <= {PTR_W{1'b0}};
         tail_q     <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         age_q      <= {AGE_W{1'b0}};
         rd_valid_q <= 1'b0;
      end else begin
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         buf_vld_q  <= buf_vld_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         age_q      <= age_d;
         rd_valid_q <= rd_valid_d;
      end
   end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Testbench for regfile_access_ctrl: register-file model, write/read
// scoreboards checked every cycle, plus directed scenario tasks.
module tb_regfile_access_ctrl;

   localparam int WB_DEPTH = 4;
   localparam int MAX_WAIT = 8;
   localparam int CW = $clog2(WB_DEPTH) + 1;

   bit           clock = 1'b0;
   bit           reset = 1'b1;
   logic         rd_req;
   logic [5:0]   rd_rs_addr, rd_rt_addr;
   logic         rd_ack, rd_valid;
   logic [31:0]  rd_rs_data, rd_rt_data;
   logic         wb_req;
   logic [5:0]   wb_addr;
   logic [31:0]  wb_data;
   logic         wb_ready;
   logic [CW-1:0] wb_count;
   logic [5:0]   rf_rs_addr, rf_rt_addr, rf_rd_addr;
   logic         rf_write;
   logic [31:0]  rf_data_in, rf_rs, rf_rt;

   int checks = 0;
   int errors = 0;

   regfile_access_ctrl #(.WB_DEPTH(WB_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset(reset),
      .rd_req(rd_req), .rd_rs_addr(rd_rs_addr), .rd_rt_addr(rd_rt_addr),
      .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_rs_data(rd_rs_data), .rd_rt_data(rd_rt_data),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_ready(wb_ready), .wb_count(wb_count),
      .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr), .rf_rd_addr(rf_rd_addr),
      .rf_write(rf_write), .rf_data_in(rf_data_in), .rf_rs(rf_rs), .rf_rt(rf_rt)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] init_val(input logic [5:0] a);
      return 32'hA5C3_0000 | {26'd0, a};
   endfunction

   // Register file model: synchronous read on non-write edges.
   logic [31:0] rf_mem [64];
   logic [63:0] rf_wr_flag = 64'd0;
   always @(posedge clock) begin
      if (rf_write === 1'b1) begin
         rf_mem[rf_rd_addr]     <= rf_data_in;
         rf_wr_flag[rf_rd_addr] <= 1'b1;
      end else begin
         rf_rs <= rf_wr_flag[rf_rs_addr] ? rf_mem[rf_rs_addr] : init_val(rf_rs_addr);
         rf_rt <= rf_wr_flag[rf_rt_addr] ? rf_mem[rf_rt_addr] : init_val(rf_rt_addr);
      end
   end

   // Scoreboard state: committed contents, pending writes, expected read data.
   typedef struct packed { logic [5:0] addr; logic [31:0] data; } wr_t;
   typedef struct packed { logic [31:0] rs; logic [31:0] rt; } rd_t;
   wr_t pend_q[$];
   rd_t exp_q[$];
   logic [31:0] base_mem [64];
   logic [63:0] base_flag = 64'd0;
   int age_m = 0;

   // Architectural value: committed value overlaid by pending writes in order.
   function automatic logic [31:0] arch_val(input logic [5:0] a);
      logic [31:0] v;
      v = base_flag[a] ? base_mem[a] : init_val(a);
      foreach (pend_q[i]) if (pend_q[i].addr == a) v = pend_q[i].data;
      return v;
   endfunction

   int   n_m;
   logic hz_m, exp_wr, exp_rd;
   wr_t  w_m;
   rd_t  r_m;

   // Per-cycle monitor at the falling edge.
   always @(negedge clock) begin
      if (reset) begin
         checks++;
         if (rd_ack !== 1'b0 || rf_write !== 1'b0 || wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_gating: rd_ack=%b rf_write=%b wb_ready=%b, required 0 0 0",
                     rd_ack, rf_write, wb_ready);
         end
         pend_q.delete();
         exp_q.delete();
         age_m = 0;
      end else begin
         n_m  = pend_q.size();
         hz_m = 1'b0;
         if (rd_req === 1'b1) begin
            foreach (pend_q[i])
               if (pend_q[i].addr == rd_rs_addr || pend_q[i].addr == rd_rt_addr) hz_m = 1'b1;
         end
         exp_wr = (n_m != 0) && (n_m == WB_DEPTH || hz_m || age_m == MAX_WAIT || rd_req !== 1'b1);
         exp_rd = (rd_req === 1'b1) && !exp_wr;
         checks++;
         if (rf_write !== exp_wr || rd_ack !== exp_rd) begin
            errors++;
            $display("FAIL op_select: rf_write=%b rd_ack=%b, required %b %b",
                     rf_write, rd_ack, exp_wr, exp_rd);
         end
         checks++;
         if (wb_count !== CW'(n_m) || wb_ready !== (n_m < WB_DEPTH)) begin
            errors++;
            $display("FAIL buffer_status: wb_count=%0d wb_ready=%b, required %0d %b",
                     wb_count, wb_ready, n_m, (n_m < WB_DEPTH));
         end
         checks++;
         if (exp_q.size() != 0) begin
            r_m = exp_q.pop_front();
            if (rd_valid !== 1'b1 || rd_rs_data !== r_m.rs || rd_rt_data !== r_m.rt) begin
               errors++;
               $display("FAIL read_data: valid=%b rs=%h rt=%h, required 1 %h %h",
                        rd_valid, rd_rs_data, rd_rt_data, r_m.rs, r_m.rt);
            end
         end else if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_rd_valid: rd_valid=%b, required 0", rd_valid);
         end
         if (rd_ack === 1'b1) begin
            r_m.rs = arch_val(rd_rs_addr);
            r_m.rt = arch_val(rd_rt_addr);
            exp_q.push_back(r_m);
         end
         if (rf_write === 1'b1) begin
            checks++;
            if (pend_q.size() == 0) begin
               errors++;
               $display("FAIL write_commit: write of addr %0d issued, required no write", rf_rd_addr);
            end else begin
               w_m = pend_q.pop_front();
               if (rf_rd_addr !== w_m.addr || rf_data_in !== w_m.data) begin
                  errors++;
                  $display("FAIL write_commit: addr=%0d data=%h, required %0d %h",
                           rf_rd_addr, rf_data_in, w_m.addr, w_m.data);
               end
               base_mem[w_m.addr]  = w_m.data;
               base_flag[w_m.addr] = 1'b1;
            end
         end
         if (wb_req === 1'b1 && wb_ready === 1'b1) begin
            w_m.addr = wb_addr;
            w_m.data = wb_data;
            pend_q.push_back(w_m);
         end
         if (n_m == 0 || exp_wr) age_m = 0;
         else if (age_m < MAX_WAIT) age_m++;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issue one read, wait (bounded) for acceptance, return the operand data.
   task automatic do_read(input logic [5:0] rs, input logic [5:0] rt,
                          output logic [31:0] rs_d, output logic [31:0] rt_d, output bit ok);
      rd_req = 1'b1; rd_rs_addr = rs; rd_rt_addr = rt; ok = 1'b0;
      for (int c = 0; c < 32 && !ok; c++) begin
         @(negedge clock);
         if (rd_ack === 1'b1) ok = 1'b1;
         step();
      end
      rd_req = 1'b0;
      @(negedge clock);
      rs_d = rd_rs_data;
      rt_d = rd_rt_data;
      ok   = ok && (rd_valid === 1'b1);
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      @(negedge clock);
      checks++;
      if (wb_count !== CW'(0) || rd_valid !== 1'b0 || rd_ack !== 1'b0 || rf_write !== 1'b0 || wb_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: count=%0d valid=%b ack=%b write=%b ready=%b, required 0 0 0 0 0",
                  wb_count, rd_valid, rd_ack, rf_write, wb_ready);
      end
      step();
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (wb_ready !== 1'b1 || wb_count !== CW'(0) || rd_valid !== 1'b0 || rf_write !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: ready=%b count=%0d valid=%b write=%b, required 1 0 0 0",
                  wb_ready, wb_count, rd_valid, rf_write);
      end
      step();
   endtask

   task automatic test_single_write();
      rd_req = 1'b0; wb_req = 1'b1; wb_addr = 6'd5; wb_data = 32'hDEADBEEF;
      @(negedge clock);
      checks++;
      if (wb_ready !== 1'b1 || rf_write !== 1'b0) begin
         errors++;
         $display("FAIL single_enq: ready=%b write=%b, required 1 0", wb_ready, rf_write);
      end
      step();
      wb_req = 1'b0;
      @(negedge clock);
      checks++;
      if (rf_write !== 1'b1 || rf_rd_addr !== 6'd5 || rf_data_in !== 32'hDEADBEEF || wb_count !== CW'(1)) begin
         errors++;
         $display("FAIL single_commit: write=%b addr=%0d data=%h count=%0d, required 1 5 deadbeef 1",
                  rf_write, rf_rd_addr, rf_data_in, wb_count);
      end
      step();
      @(negedge clock);
      checks++;
      if (wb_count !== CW'(0) || rf_write !== 1'b0) begin
         errors++;
         $display("FAIL single_drained: count=%0d write=%b, required 0 0", wb_count, rf_write);
      end
      step();
   endtask

   task automatic test_raw_hazard();
      wb_req = 1'b1; wb_addr = 6'd3; wb_data = 32'h11;
      step();
      wb_req = 1'b0; rd_req = 1'b1; rd_rs_addr = 6'd3; rd_rt_addr = 6'd2;
      @(negedge clock);
      checks++;
      if (rd_ack !== 1'b0 || rf_write !== 1'b1) begin
         errors++;
         $display("FAIL raw_stall: ack=%b write=%b, required 0 1", rd_ack, rf_write);
      end
      step();
      @(negedge clock);
      checks++;
      if (rd_ack !== 1'b1) begin
         errors++;
         $display("FAIL raw_accept: ack=%b, required 1", rd_ack);
      end
      step();
      rd_req = 1'b0;
      @(negedge clock);
      checks++;
      if (rd_valid !== 1'b1 || rd_rs_data !== 32'h11 || rd_rt_data !== init_val(6'd2)) begin
         errors++;
         $display("FAIL raw_data: valid=%b rs=%h rt=%h, required 1 00000011 %h",
                  rd_valid, rd_rs_data, rd_rt_data, init_val(6'd2));
      end
      step();
   endtask

   task automatic test_full();
      bit drained;
      rd_req = 1'b1; rd_rs_addr = 6'd10; rd_rt_addr = 6'd11;
      for (int k = 0; k < 4; k++) begin
         wb_req = 1'b1; wb_addr = 6'(20 + k); wb_data = 32'h100 + 32'(k);
         @(negedge clock);
         checks++;
         if (wb_ready !== 1'b1 || rd_ack !== 1'b1) begin
            errors++;
            $display("FAIL full_fill%0d: ready=%b ack=%b, required 1 1", k, wb_ready, rd_ack);
         end
         step();
      end
      wb_req = 1'b0;
      @(negedge clock);
      checks++;
      if (wb_ready !== 1'b0 || wb_count !== CW'(4) || rf_write !== 1'b1 || rd_ack !== 1'b0) begin
         errors++;
         $display("FAIL full_force: ready=%b count=%0d write=%b ack=%b, required 0 4 1 0",
                  wb_ready, wb_count, rf_write, rd_ack);
      end
      step();
      @(negedge clock);
      checks++;
      if (wb_ready !== 1'b1 || wb_count !== CW'(3) || rd_ack !== 1'b1) begin
         errors++;
         $display("FAIL full_recover: ready=%b count=%0d ack=%b, required 1 3 1",
                  wb_ready, wb_count, rd_ack);
      end
      step();
      rd_req = 1'b0;
      drained = 1'b0;
      for (int c = 0; c < 16 && !drained; c++) begin
         @(negedge clock);
         if (wb_count === CW'(0)) drained = 1'b1;
         step();
      end
      checks++;
      if (!drained) begin
         errors++;
         $display("FAIL full_drain: count=%0d after 16 cycles, required 0", wb_count);
      end
   endtask

   task automatic test_max_wait();
      rd_req = 1'b1; rd_rs_addr = 6'd40; rd_rt_addr = 6'd41;
      for (int r = 0; r < 2; r++) begin
         wb_req = 1'b1; wb_addr = 6'(30 + r); wb_data = 32'hCAFE_0000 + 32'(r);
         @(negedge clock);
         checks++;
         if (rd_ack !== 1'b1) begin
            errors++;
            $display("FAIL age_enq%0d: ack=%b, required 1", r, rd_ack);
         end
         step();
         wb_req = 1'b0;
         for (int j = 0; j < MAX_WAIT; j++) begin
            @(negedge clock);
            checks++;
            if (rd_ack !== 1'b1 || rf_write !== 1'b0) begin
               errors++;
               $display("FAIL age_read%0d_%0d: ack=%b write=%b, required 1 0", r, j, rd_ack, rf_write);
            end
            step();
         end
         @(negedge clock);
         checks++;
         if (rd_ack !== 1'b0 || rf_write !== 1'b1) begin
            errors++;
            $display("FAIL age_force%0d: ack=%b write=%b, required 0 1", r, rd_ack, rf_write);
         end
         step();
      end
      rd_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 6; k++) begin
         rd_req = 1'b1; rd_rs_addr = 6'(k); rd_rt_addr = 6'(63 - k);
         @(negedge clock);
         checks++;
         if (rd_ack !== 1'b1 || (k > 0 && rd_valid !== 1'b1)) begin
            errors++;
            $display("FAIL b2b_%0d: ack=%b valid=%b, required 1 1", k, rd_ack, rd_valid);
         end
         step();
      end
      rd_req = 1'b0;
      @(negedge clock);
      checks++;
      if (rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_last: valid=%b, required 1", rd_valid);
      end
      step();
   endtask

   task automatic test_same_cycle();
      logic [31:0] a, b;
      bit ok;
      rd_req = 1'b1; rd_rs_addr = 6'd7; rd_rt_addr = 6'd8;
      wb_req = 1'b1; wb_addr = 6'd7; wb_data = 32'h99;
      @(negedge clock);
      checks++;
      if (rd_ack !== 1'b1) begin
         errors++;
         $display("FAIL same_accept: ack=%b, required 1", rd_ack);
      end
      step();
      rd_req = 1'b0; wb_req = 1'b0;
      @(negedge clock);
      checks++;
      if (rd_valid !== 1'b1 || rd_rs_data !== init_val(6'd7) || rf_write !== 1'b1 ||
          rf_rd_addr !== 6'd7 || rf_data_in !== 32'h99) begin
         errors++;
         $display("FAIL same_old: valid=%b rs=%h write=%b addr=%0d data=%h, required 1 %h 1 7 00000099",
                  rd_valid, rd_rs_data, rf_write, rf_rd_addr, rf_data_in, init_val(6'd7));
      end
      step();
      do_read(6'd7, 6'd7, a, b, ok);
      checks++;
      if (!ok || a !== 32'h99 || b !== 32'h99) begin
         errors++;
         $display("FAIL same_new: ok=%b rs=%h rt=%h, required 1 00000099 00000099", ok, a, b);
      end
   endtask

   task automatic test_same_addr();
      logic [31:0] a, b;
      bit ok;
      rd_req = 1'b0;
      wb_req = 1'b1; wb_addr = 6'd9; wb_data = 32'h1;
      step();
      wb_data = 32'h2;
      step();
      wb_addr = 6'd0; wb_data = 32'h5A5A;
      step();
      wb_req = 1'b0;
      do_read(6'd9, 6'd0, a, b, ok);
      checks++;
      if (!ok || a !== 32'h2 || b !== 32'h5A5A) begin
         errors++;
         $display("FAIL same_addr: ok=%b r9=%h r0=%h, required 1 00000002 00005a5a", ok, a, b);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] a, b;
      bit ok;
      rd_req = 1'b1; rd_rs_addr = 6'd40; rd_rt_addr = 6'd41;
      for (int k = 0; k < 3; k++) begin
         wb_req = 1'b1; wb_addr = 6'(12 + k); wb_data = 32'hBAD0 + 32'(k);
         step();
      end
      wb_req = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (wb_count !== CW'(3) || rf_write !== 1'b0 || rd_ack !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_hold: count=%0d write=%b ack=%b, required 3 0 0", wb_count, rf_write, rd_ack);
      end
      step();
      reset = 1'b0; rd_req = 1'b0;
      @(negedge clock);
      checks++;
      if (wb_count !== CW'(0) || rf_write !== 1'b0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_clear: count=%0d write=%b valid=%b, required 0 0 0",
                  wb_count, rf_write, rd_valid);
      end
      step();
      do_read(6'd12, 6'd13, a, b, ok);
      checks++;
      if (!ok || a !== init_val(6'd12) || b !== init_val(6'd13)) begin
         errors++;
         $display("FAIL rstmid_old: ok=%b r12=%h r13=%h, required 1 %h %h",
                  ok, a, b, init_val(6'd12), init_val(6'd13));
      end
   endtask

   initial begin
      reset = 1'b1; rd_req = 1'b0; rd_rs_addr = 6'd0; rd_rt_addr = 6'd0;
      wb_req = 1'b0; wb_addr = 6'd0; wb_data = 32'd0;
      test_reset();
      test_single_write();
      test_raw_hazard();
      test_full();
      test_max_wait();
      test_back_to_back();
      test_same_cycle();
      test_same_addr();
      test_reset_mid();
      step(); step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
